// File: rtl/soc_new_cpu_oci_pkg.sv
// Shared definitions for the OCI data-trace compression path.
package soc_new_cpu_oci_pkg;

   localparam int SLOTS  = 15;
   localparam int CODE_W = 2;
   localparam int BUF_W  = SLOTS * CODE_W;
   localparam int CNT_W  = 4;

   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(SLOTS);

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_FLUSH = 2'd1,
      ST_DRAIN = 2'd2,
      ST_ENDED = 2'd3
   } dct_state_e;

   localparam logic [CODE_W-1:0] TC_0 = 2'b00;
   localparam logic [CODE_W-1:0] TC_1 = 2'b01;
   localparam logic [CODE_W-1:0] TC_2 = 2'b10;
   localparam logic [CODE_W-1:0] TC_3 = 2'b11;

endpackage

// File: rtl/soc_new_cpu_oci_dct_packer_if.sv
// Trace-in / packed-word-out signal bundle for the DCT packer.
interface soc_new_cpu_oci_dct_packer_if;
   import soc_new_cpu_oci_pkg::*;

   logic              trc_on;
   logic              tr_valid;
   logic [CODE_W-1:0] tr_code;
   logic              end_req;
   logic              out_ready;
   logic [BUF_W-1:0]  dct_buffer;
   logic [CNT_W-1:0]  dct_count;
   logic              out_valid;
   logic [BUF_W-1:0]  out_word;
   logic [CNT_W-1:0]  out_count;
   logic              overflow;
   logic              test_ending;
   logic              test_has_ended;

   modport master (
      output trc_on, tr_valid, tr_code, end_req, out_ready,
      input  dct_buffer, dct_count, out_valid, out_word, out_count,
             overflow, test_ending, test_has_ended
   );

   modport slave (
      input  trc_on, tr_valid, tr_code, end_req, out_ready,
      output dct_buffer, dct_count, out_valid, out_word, out_count,
             overflow, test_ending, test_has_ended
   );

endinterface

// File: rtl/soc_new_cpu_oci_dct_outreg.sv
// Valid/ready holding register for packed words; a load wins over an accept.
module soc_new_cpu_oci_dct_outreg
   import soc_new_cpu_oci_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             ready,
   input  logic [BUF_W-1:0] din_word,
   input  logic [CNT_W-1:0] din_count,
   output logic             valid,
   output logic [BUF_W-1:0] word,
   output logic [CNT_W-1:0] count
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= 1'b0;
         word  <= '0;
         count <= '0;
      end else if (load) begin
         valid <= 1'b1;
         word  <= din_word;
         count <= din_count;
      end else if (ready && valid) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/soc_new_cpu_oci_dct_packer.sv
// Packs 2-bit trace codes into 30-bit words and sequences the end of test.
//  state    | meaning
//  ST_RUN   | accepting trace codes
//  ST_FLUSH | pushing a partial buffer to the output register
//  ST_DRAIN | waiting for the last word to be consumed
//  ST_ENDED | test over, inputs ignored until reset
module soc_new_cpu_oci_dct_packer
   import soc_new_cpu_oci_pkg::*;
(
   input logic                          clk,
   input logic                          jrst_n,
   soc_new_cpu_oci_dct_packer_if.slave  bus
);

   dct_state_e       state_q, state_d;
   logic [BUF_W-1:0] buf_q;
   logic [CNT_W-1:0] cnt_q;
   logic             ovf_q;
   logic             ending_q;
   logic             ended_q;

   logic             out_valid;
   logic [BUF_W-1:0] out_word;
   logic [CNT_W-1:0] out_count;

   logic slot_free;
   logic xfer;
   logic code_in;
   logic acc;
   logic drop;

   always_comb begin
      slot_free = !out_valid || bus.out_ready;
      xfer      = slot_free && ((cnt_q == CNT_FULL) ||
                                ((state_q == ST_FLUSH) && (cnt_q != '0)));
      code_in   = (state_q == ST_RUN) && bus.trc_on && bus.tr_valid;
      acc       = code_in && ((cnt_q != CNT_FULL) || xfer);
      drop      = code_in && (cnt_q == CNT_FULL) && !slot_free;
   end

   always_ff @(posedge clk or negedge jrst_n) begin
      if (!jrst_n) begin
         buf_q <= '0;
         cnt_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         if (acc && xfer) begin
            buf_q <= {{(BUF_W-CODE_W){1'b0}}, bus.tr_code};
            cnt_q <= CNT_W'(1);
         end else if (acc) begin
            buf_q <= {buf_q[BUF_W-CODE_W-1:0], bus.tr_code};
            cnt_q <= cnt_q + CNT_W'(1);
         end else if (xfer) begin
            buf_q <= '0;
            cnt_q <= '0;
         end
         if (drop) begin
            ovf_q <= 1'b1;
         end
      end
   end

   soc_new_cpu_oci_dct_outreg u_outreg (
      .clk       (clk),
      .rst_n     (jrst_n),
      .load      (xfer),
      .ready     (bus.out_ready),
      .din_word  (buf_q),
      .din_count (cnt_q),
      .valid     (out_valid),
      .word      (out_word),
      .count     (out_count)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RUN: begin
            if (bus.end_req) state_d = ST_FLUSH;
         end
         ST_FLUSH: begin
            if (cnt_q == '0 || xfer) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (!out_valid || bus.out_ready) state_d = ST_ENDED;
         end
         ST_ENDED: state_d = ST_ENDED;
         default:  state_d = ST_RUN;
      endcase
   end

   // Status flags follow the next state so they line up with state_q.
   always_ff @(posedge clk or negedge jrst_n) begin
      if (!jrst_n) begin
         state_q  <= ST_RUN;
         ending_q <= 1'b0;
         ended_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         ending_q <= (state_d == ST_FLUSH) || (state_d == ST_DRAIN);
         ended_q  <= (state_d == ST_ENDED);
      end
   end

   assign bus.dct_buffer     = buf_q;
   assign bus.dct_count      = cnt_q;
   assign bus.out_valid      = out_valid;
   assign bus.out_word       = out_word;
   assign bus.out_count      = out_count;
   assign bus.overflow       = ovf_q;
   assign bus.test_ending    = ending_q;
   assign bus.test_has_ended = ended_q;

endmodule

// File: tb/tb_soc_new_cpu_oci_dct_packer.sv
// Directed bench for the DCT packer: fill, back-to-back, stall, flushes, reset.
module tb_soc_new_cpu_oci_dct_packer;
   import soc_new_cpu_oci_pkg::*;

   logic clk = 1'b0;
   logic jrst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   soc_new_cpu_oci_dct_packer_if bus ();

   soc_new_cpu_oci_dct_packer dut (
      .clk    (clk),
      .jrst_n (jrst_n),
      .bus    (bus)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [1:0] c);
      bus.tr_valid = 1'b1;
      bus.tr_code  = c;
      tick();
   endtask

   task automatic idle();
      bus.tr_valid = 1'b0;
      tick();
   endtask

   initial begin
      bus.trc_on    = 1'b0;
      bus.tr_valid  = 1'b0;
      bus.tr_code   = 2'b00;
      bus.end_req   = 1'b0;
      bus.out_ready = 1'b0;
      #1;
      chk("rst_count",  32'(bus.dct_count), 32'd0);
      chk("rst_buffer", 32'(bus.dct_buffer), 32'd0);
      chk("rst_valid",  32'(bus.out_valid), 32'd0);
      chk("rst_ended",  32'(bus.test_has_ended), 32'd0);
      tick();
      @(negedge clk);
      jrst_n = 1'b1;
      tick();

      // fill with 01,10,11,00 repeating
      bus.trc_on    = 1'b1;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 15; i++) begin
         logic [1:0] c;
         c = 2'((i + 1) % 4);
         send(c);
      end
      chk("fill_count",  32'(bus.dct_count), 32'd15);
      chk("fill_buffer", 32'(bus.dct_buffer), 32'h1B1B1B1B);
      chk("fill_valid0", 32'(bus.out_valid), 32'd0);
      idle();
      chk("fill_valid",  32'(bus.out_valid), 32'd1);
      chk("fill_word",   32'(bus.out_word), 32'h1B1B1B1B);
      chk("fill_ocount", 32'(bus.out_count), 32'd15);
      chk("fill_cnt0",   32'(bus.dct_count), 32'd0);
      idle();
      chk("fill_taken",  32'(bus.out_valid), 32'd0);

      // back-to-back: 16th code lands in the transfer cycle
      for (int i = 0; i < 15; i++) send(TC_3);
      chk("b2b_buffer15", 32'(bus.dct_buffer), 32'h3FFFFFFF);
      send(TC_1);
      chk("b2b_buffer", 32'(bus.dct_buffer), 32'h00000001);
      chk("b2b_count",  32'(bus.dct_count), 32'd1);
      chk("b2b_valid",  32'(bus.out_valid), 32'd1);
      chk("b2b_word",   32'(bus.out_word), 32'h3FFFFFFF);
      chk("b2b_ovf",    32'(bus.overflow), 32'd0);

      // stall with a word pending, then overflow
      bus.out_ready = 1'b0;
      for (int i = 0; i < 14; i++) send(TC_2);
      chk("stall_count",  32'(bus.dct_count), 32'd15);
      chk("stall_buffer", 32'(bus.dct_buffer), 32'h1AAAAAAA);
      chk("stall_word",   32'(bus.out_word), 32'h3FFFFFFF);
      send(TC_3);
      chk("ovf_flag",   32'(bus.overflow), 32'd1);
      chk("ovf_count",  32'(bus.dct_count), 32'd15);
      chk("ovf_buffer", 32'(bus.dct_buffer), 32'h1AAAAAAA);
      bus.tr_valid  = 1'b0;
      bus.out_ready = 1'b1;
      tick();
      chk("unstall_valid",  32'(bus.out_valid), 32'd1);
      chk("unstall_word",   32'(bus.out_word), 32'h1AAAAAAA);
      chk("unstall_ocount", 32'(bus.out_count), 32'd15);
      chk("unstall_cnt0",   32'(bus.dct_count), 32'd0);
      tick();
      chk("unstall_taken", 32'(bus.out_valid), 32'd0);
      chk("ovf_sticky",    32'(bus.overflow), 32'd1);

      // partial flush of 5 codes
      bus.out_ready = 1'b0;
      send(TC_1); send(TC_2); send(TC_3); send(TC_0); send(TC_1);
      chk("part_count",  32'(bus.dct_count), 32'd5);
      chk("part_buffer", 32'(bus.dct_buffer), 32'h000001B1);
      bus.tr_valid = 1'b0;
      bus.end_req  = 1'b1;
      tick();
      bus.end_req = 1'b0;
      chk("part_ending", 32'(bus.test_ending), 32'd1);
      chk("part_nvalid", 32'(bus.out_valid), 32'd0);
      tick();
      chk("part_valid",  32'(bus.out_valid), 32'd1);
      chk("part_word",   32'(bus.out_word), 32'h000001B1);
      chk("part_ocount", 32'(bus.out_count), 32'd5);
      chk("part_cnt0",   32'(bus.dct_count), 32'd0);
      tick();
      chk("drain_hold",  32'(bus.test_ending), 32'd1);
      chk("drain_ended0", 32'(bus.test_has_ended), 32'd0);
      bus.out_ready = 1'b1;
      tick();
      chk("part_ended",   32'(bus.test_has_ended), 32'd1);
      chk("part_ending0", 32'(bus.test_ending), 32'd0);
      chk("part_taken",   32'(bus.out_valid), 32'd0);
      send(TC_1);
      bus.tr_valid = 1'b0;
      chk("ended_ignore", 32'(bus.dct_count), 32'd0);

      // empty flush
      jrst_n = 1'b0;
      #1;
      jrst_n = 1'b1;
      chk("empty_rst_ended", 32'(bus.test_has_ended), 32'd0);
      chk("empty_rst_ovf",   32'(bus.overflow), 32'd0);
      bus.end_req = 1'b1;
      tick();
      bus.end_req = 1'b0;
      chk("empty_flush", 32'(bus.test_ending), 32'd1);
      tick();
      chk("empty_drain", 32'(bus.test_ending), 32'd1);
      chk("empty_nv1",   32'(bus.out_valid), 32'd0);
      tick();
      chk("empty_ended", 32'(bus.test_has_ended), 32'd1);
      chk("empty_endg0", 32'(bus.test_ending), 32'd0);
      chk("empty_nv2",   32'(bus.out_valid), 32'd0);

      // reset while stuck in FLUSH with a word pending
      jrst_n = 1'b0;
      #1;
      jrst_n = 1'b1;
      bus.out_ready = 1'b0;
      for (int i = 0; i < 15; i++) send(TC_2);
      idle();
      chk("mid_valid", 32'(bus.out_valid), 32'd1);
      send(TC_1); send(TC_1);
      bus.tr_valid = 1'b0;
      bus.end_req  = 1'b1;
      tick();
      bus.end_req = 1'b0;
      tick();
      chk("mid_ending", 32'(bus.test_ending), 32'd1);
      chk("mid_count",  32'(bus.dct_count), 32'd2);
      chk("mid_valid2", 32'(bus.out_valid), 32'd1);
      jrst_n = 1'b0;
      #1;
      chk("arst_valid",  32'(bus.out_valid), 32'd0);
      chk("arst_word",   32'(bus.out_word), 32'd0);
      chk("arst_count",  32'(bus.dct_count), 32'd0);
      chk("arst_buffer", 32'(bus.dct_buffer), 32'd0);
      chk("arst_ending", 32'(bus.test_ending), 32'd0);
      #1;
      jrst_n = 1'b1;
      send(TC_2); send(TC_3);
      bus.tr_valid = 1'b0;
      chk("post_count",  32'(bus.dct_count), 32'd2);
      chk("post_buffer", 32'(bus.dct_buffer), 32'h0000000B);
      chk("post_ending", 32'(bus.test_ending), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
